// File: rtl/decode_skid_stage.sv
// ----------------------------------------------------------------------------
// decode_skid_stage
//
// Instruction-decode pipeline stage between fetch and execute. Each accepted
// RV32I instruction is classified by immediate format and its fully extended
// immediate is computed once, at capture, and stored alongside the
// instruction and PC. A registered output entry (OUT) plus one skid entry
// (SKID) give full throughput under backpressure. A synchronous flush empties
// the stage for branch redirect.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             discard all held and same-cycle incoming instructions
//   in_valid/in_ready fetch handshake (in_ready is a flop output)
//   in_inst, in_pc    instruction word and its PC
//   out_valid/out_ready execute handshake
//   out_inst, out_pc  instruction and PC of the output entry
//   out_imm           extended immediate of the output entry
//   out_imm_type      0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
// ----------------------------------------------------------------------------
module decode_skid_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [2:0]            out_imm_type
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_S     = 3'd2;
    localparam logic [2:0] T_B     = 3'd3;
    localparam logic [2:0] T_U     = 3'd4;
    localparam logic [2:0] T_J     = 3'd5;
    localparam logic [2:0] T_SHAMT = 3'd6;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [31:0]           imm32;
    logic [2:0]            dec_type;
    logic [DATA_WIDTH-1:0] dec_imm;

    always_comb begin
        opcode   = in_inst[6:0];
        funct3   = in_inst[14:12];
        imm32    = 32'd0;
        dec_type = T_NONE;
        case (opcode)
            7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                dec_type = T_I;
                imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift-immediate: only the 5-bit shamt is an operand;
                    // funct7 (arith/logical select) stays in the inst word.
                    dec_type = T_SHAMT;
                    imm32    = {27'd0, in_inst[24:20]};
                end else begin
                    dec_type = T_I;
                    imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
                end
            end
            7'b0100011: begin
                dec_type = T_S;
                imm32    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec_type = T_B;
                imm32    = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_type = T_U;
                imm32    = {in_inst[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_type = T_J;
                imm32    = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
            end
            default: begin
                dec_type = T_NONE;
                imm32    = 32'd0;
            end
        endcase
    end

    // imm32 is already correct at 32 bits; widen by replicating bit 31
    // (SHAMT has bit 31 clear, so this is a zero-extension for it).
    assign dec_imm = DATA_WIDTH'($signed(imm32));

    // ------------------------------------------------------------------
    // Storage and control
    // ------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic [31:0]           out_inst_q, out_inst_d;
    logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [DATA_WIDTH-1:0] out_imm_q, out_imm_d;
    logic [2:0]            out_type_q, out_type_d;
    logic [31:0]           skid_inst_q, skid_inst_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_imm_q, skid_imm_d;
    logic [2:0]            skid_type_q, skid_type_d;

    logic accept;
    logic consume;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_imm_d   = out_imm_q;
        out_type_d  = out_type_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_imm_d  = skid_imm_q;
        skid_type_d = skid_type_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d    = ST_ONE;
                    out_inst_d = in_inst;
                    out_pc_d   = in_pc;
                    out_imm_d  = dec_imm;
                    out_type_d = dec_type;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    out_inst_d = in_inst;
                    out_pc_d   = in_pc;
                    out_imm_d  = dec_imm;
                    out_type_d = dec_type;
                end else if (accept) begin
                    state_d     = ST_TWO;
                    skid_inst_d = in_inst;
                    skid_pc_d   = in_pc;
                    skid_imm_d  = dec_imm;
                    skid_type_d = dec_type;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a consume can happen.
                if (consume) begin
                    state_d    = ST_ONE;
                    out_inst_d = skid_inst_q;
                    out_pc_d   = skid_pc_q;
                    out_imm_d  = skid_imm_q;
                    out_type_d = skid_type_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush overrides every transition; data registers keep stale
        // contents but are invisible once out_valid drops.
        if (flush) begin
            state_d = ST_EMPTY;
        end

        // Registered ready: depends only on the next state, so there is no
        // combinational path from in_valid/out_ready/flush to in_ready.
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            out_imm_q   <= '0;
            out_type_q  <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            skid_imm_q  <= '0;
            skid_type_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_imm_q   <= out_imm_d;
            out_type_q  <= out_type_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_imm_q  <= skid_imm_d;
            skid_type_q <= skid_type_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_inst     = out_inst_q;
    assign out_pc       = out_pc_q;
    assign out_imm      = out_imm_q;
    assign out_imm_type = out_type_q;

endmodule

// File: tb/tb_decode_skid_stage.sv
module tb_decode_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_imm_type;

    decode_skid_stage #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_pc       (out_pc),
        .out_imm      (out_imm),
        .out_imm_type (out_imm_type)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  typ;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  typ;
    } ent_t;

    vec_t tbl [7];
    ent_t model_q [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [2:0] typ);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".out_inst"},  64'(out_inst),  64'(inst));
        chk({tag, ".out_pc"},    64'(out_pc),    64'(pc));
        chk({tag, ".out_imm"},   64'(out_imm),   64'(imm));
        chk({tag, ".out_type"},  64'(out_imm_type), 64'(typ));
    endtask

    logic [31:0] ins_a, ins_b, ins_c;

    initial begin
        tbl[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1};
        tbl[1] = '{32'h4030D093, 32'h00000003, 3'd6};
        tbl[2] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3};
        tbl[3] = '{32'h123450B7, 32'h12345000, 3'd4};
        tbl[4] = '{32'hFF9FF06F, 32'hFFFFFFF8, 3'd5};
        tbl[5] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2};
        tbl[6] = '{32'h00000033, 32'h00000000, 3'd0};
        ins_a = tbl[0].inst;
        ins_b = tbl[3].inst;
        ins_c = tbl[5].inst;

        // ---------------- reset ----------------
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_inst = 32'hFFF00093; in_pc = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.in_ready",  64'(in_ready),  64'd0);
            chk("rst.out_valid", 64'(out_valid), 64'd0);
        end
        chk("rst.out_inst", 64'(out_inst), 64'd0);
        chk("rst.out_pc",   64'(out_pc),   64'd0);
        chk("rst.out_imm",  64'(out_imm),  64'd0);
        chk("rst.out_type", 64'(out_imm_type), 64'd0);
        rst = 1'b0;
        step();
        chk("rel.in_ready",  64'(in_ready),  64'd1);
        chk("rel.out_valid", 64'(out_valid), 64'd0);
        $display("reset sequence done");

        // ---------------- immediate formats ----------------
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            in_valid = 1'b1;
            in_inst  = tbl[i].inst;
            in_pc    = 32'h1000 + 32'(i) * 4;
            step();
            chk_out("fmt", tbl[i].inst, 32'h1000 + 32'(i) * 4, tbl[i].imm, tbl[i].typ);
            chk("fmt.in_ready", 64'(in_ready), 64'd1);
            $display("fmt inst=%08h imm=%08h type=%0d", out_inst, out_imm, out_imm_type);
        end
        in_valid = 1'b0;
        step();
        chk("drain.out_valid", 64'(out_valid), 64'd0);

        // ---------------- backpressure A,B,C ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = ins_a; in_pc = 32'h2000;
        step();
        chk_out("bp.A", ins_a, 32'h2000, tbl[0].imm, tbl[0].typ);
        chk("bp.ready1", 64'(in_ready), 64'd1);
        in_inst = ins_b; in_pc = 32'h2004;
        step();
        chk("bp.ready_after_B", 64'(in_ready), 64'd0);
        chk_out("bp.holdA1", ins_a, 32'h2000, tbl[0].imm, tbl[0].typ);
        in_inst = ins_c; in_pc = 32'h2008;
        step();
        chk("bp.ready_C_held", 64'(in_ready), 64'd0);
        chk_out("bp.holdA2", ins_a, 32'h2000, tbl[0].imm, tbl[0].typ);
        out_ready = 1'b1;
        step();
        chk_out("bp.B", ins_b, 32'h2004, tbl[3].imm, tbl[3].typ);
        chk("bp.ready_reopen", 64'(in_ready), 64'd1);
        step();
        chk_out("bp.C", ins_c, 32'h2008, tbl[5].imm, tbl[5].typ);
        in_valid = 1'b0;
        step();
        chk("bp.empty", 64'(out_valid), 64'd0);
        $display("backpressure sequence done");

        // ---------------- flush in TWO ----------------
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = ins_a; in_pc = 32'h3000;
        step();
        in_inst = ins_b; in_pc = 32'h3004;
        step();
        chk("fl.two_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_inst = ins_c; in_pc = 32'h3008;
        step();
        chk("fl.out_valid", 64'(out_valid), 64'd0);
        chk("fl.in_ready",  64'(in_ready),  64'd1);
        flush = 1'b0; in_inst = tbl[4].inst; in_pc = 32'h300C;
        step();
        chk_out("fl.next", tbl[4].inst, 32'h300C, tbl[4].imm, tbl[4].typ);
        // accept in the same cycle as flush must be discarded
        flush = 1'b1; in_inst = ins_c; in_pc = 32'h3010;
        step();
        chk("fl.acc_drop1", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("fl.acc_drop2", 64'(out_valid), 64'd0);
        $display("flush sequence done");

        // ---------------- reset mid-transfer ----------------
        in_valid = 1'b1; in_inst = ins_a; in_pc = 32'h4000;
        step();
        in_inst = ins_b; in_pc = 32'h4004;
        step();
        rst = 1'b1;
        step();
        chk("mrst.out_valid", 64'(out_valid), 64'd0);
        chk("mrst.out_inst",  64'(out_inst),  64'd0);
        chk("mrst.in_ready",  64'(in_ready),  64'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("mrst.release", 64'(in_ready), 64'd1);
        $display("mid-transfer reset done");

        // ---------------- randomized vs queue model ----------------
        model_q.delete();
        for (int k = 0; k < 10000; k++) begin
            logic seen_ready, seen_valid;
            int idx;
            ent_t e;
            idx       = $urandom_range(0, 6);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            in_inst   = tbl[idx].inst;
            in_pc     = $urandom;
            e = '{tbl[idx].inst, in_pc, tbl[idx].imm, tbl[idx].typ};
            seen_ready = in_ready;
            seen_valid = out_valid;
            step();
            if (seen_valid && out_ready && model_q.size() > 0) void'(model_q.pop_front());
            if (flush) model_q.delete();
            else if (in_valid && seen_ready) model_q.push_back(e);
            chk("rnd.in_ready",  64'(in_ready),  64'(model_q.size() < 2));
            chk("rnd.out_valid", 64'(out_valid), 64'(model_q.size() > 0));
            if (model_q.size() > 0)
                chk_out("rnd", model_q[0].inst, model_q[0].pc, model_q[0].imm, model_q[0].typ);
        end
        $display("random phase done, 10000 cycles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_skid_stage.md
# decode_skid_stage

Instruction-decode pipeline stage between fetch and execute. Accepts instructions over a valid/ready handshake and classifies each by immediate format. Forms the fully extended immediate and presents instruction, PC and immediate to execute through a registered output. A 2-entry skid buffer gives full throughput under backpressure, and a synchronous flush supports branch redirect.

## Interface
- DATA_WIDTH, 32, width of PC and immediate datapath; must be >= 32.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming instructions (branch redirect)
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept; registered
- in_inst  in  32  RV32I instruction word
- in_pc  in  DATA_WIDTH  PC of in_inst
- out_valid  out  1  output entry valid
- out_ready  in  1  execute consumes output this cycle
- out_inst  out  32  instruction of output entry
- out_pc  out  DATA_WIDTH  PC of output entry
- out_imm  out  DATA_WIDTH  extended immediate of output entry
- out_imm_type  out  3  0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT

## Operation
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Each accepted instruction is decoded at capture. The immediate and type are stored with the entry and are never recomputed.
- Classification uses opcode inst[6:0]:
  - 0000011, 0010011, 1100111, 1110011, 0001111 → I, except that 0010011 with funct3 inst[14:12] of 001 or 101 → SHAMT.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - All other opcodes → type 0, imm 0.
- Immediate values; "sext" means sign-extend to DATA_WIDTH:
  - I: sext(inst[31:20]).
  - SHAMT: zero-extend inst[24:20]; funct7 is dropped.
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: {inst[31:12], 12'b0}, sign-extended above bit 31.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- Storage: an output register (OUT) plus one skid register (SKID). FSM states:
  - EMPTY: OUT and SKID both invalid.
  - ONE: OUT valid, SKID invalid.
  - TWO: OUT and SKID both valid.
- Transitions, when flush=0:
  - EMPTY: accept → ONE, with OUT loaded.
  - ONE, accept & consume → ONE, with OUT loaded with the new entry.
  - ONE, accept & !consume → TWO, with SKID loaded.
  - ONE, !accept & consume → EMPTY.
  - Otherwise hold.
  - TWO: consume → ONE, with SKID moved to OUT. Otherwise hold. No accept is possible in TWO.
- in_ready next-state = (next state != TWO).
- Order is strictly FIFO. No entry is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_* is held stable.

## Timing
- Reset (rst=1 at a clock edge): state EMPTY, out_valid=0, out_inst=0, out_pc=0, out_imm=0, out_imm_type=0. in_ready=0 while rst is sampled high, and 1 in the first cycle after rst deasserts.
- Latency: an instruction accepted at edge N appears at out_* with out_valid=1 after edge N (one cycle) when OUT is empty or being consumed.
- Throughput: 1 instruction per cycle with out_ready held high.
- in_ready is a flop output with no combinational path from in_valid, out_ready or flush.
- in_ready drops to 0 the cycle after the second entry is captured without a consume. It returns to 1 the cycle after a consume in TWO.
- Flush at edge N: state → EMPTY, out_valid=0 after edge N, and in_ready=1.
  - An instruction accepted in the same cycle as flush is discarded.
  - A consume in the same cycle as flush is still a valid transfer to execute.
  - flush takes priority over every transition.
- rst dominates flush.
- Reset asserted mid-transfer discards both entries. There is no partial output.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → in_ready=0 and out_valid=0 throughout; all out_* = 0; in_ready=1 in the first cycle after release.
- Immediate formats, with out_ready=1, one per cycle:
  - 0xFFF00093 → imm 0xFFFFFFFF, type 1.
  - 0x4030D093 → imm 0x00000003, type 6.
  - 0xFE000EE3 → imm 0xFFFFFFFC, type 3.
  - 0x123450B7 → imm 0x12345000, type 4.
  - 0xFF9FF06F → imm 0xFFFFFFF8, type 5.
  - 0xFE112E23 → imm 0xFFFFFFFC, type 2.
  - 0x00000033 → imm 0, type 0.
  - Each result appears one cycle after accept, with matching PC.
- Backpressure: out_ready=0; offer A, B, C back-to-back → A and B accepted; in_ready=0 the cycle after B; C held by fetch. Then out_ready=1 → A, B, C emerge on consecutive cycles with no loss or duplication.
- Flush in TWO with in_valid=1 → out_valid=0 next cycle, in_ready=1, the offered instruction discarded; the next accepted instruction appears normally.
- Randomized in_valid/out_ready/flush over 10k cycles vs. a queue model → order, values and the in_ready rule match; out_* stable while stalled.
